// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard-control bundle: ID/EX source info, branch/memory status in,
// stall/flush/freeze controls plus event counters and FSM state out.
interface hazard_ctrl_if;
  logic [4:0]  readReg1_IF_ID;
  logic [4:0]  readReg2_IF_ID;
  logic        useReg1_IF_ID;
  logic        useReg2_IF_ID;
  logic [4:0]  writeReg_ID_EX;
  logic        MemRead_ID_EX;
  logic        branch_EX_MEM;
  logic        mem_busy;
  logic        PCWrite;
  logic        IF_ID_Write;
  logic        IF_ID_Flush;
  logic        ID_EX_Flush;
  logic        EX_MEM_Flush;
  logic        pipe_freeze;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic [1:0]  state;

  modport slave (
    input  readReg1_IF_ID, readReg2_IF_ID, useReg1_IF_ID, useReg2_IF_ID,
           writeReg_ID_EX, MemRead_ID_EX, branch_EX_MEM, mem_busy,
    output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush,
           pipe_freeze, stall_cnt, flush_cnt, state
  );

  modport master (
    output readReg1_IF_ID, readReg2_IF_ID, useReg1_IF_ID, useReg2_IF_ID,
           writeReg_ID_EX, MemRead_ID_EX, branch_EX_MEM, mem_busy,
    input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush,
           pipe_freeze, stall_cnt, flush_cnt, state
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller: memory-busy freeze, taken-branch flush (possibly deferred
// across a freeze) and load-use stall, with saturating event counters.
module hazard_ctrl (
  input logic         clk,
  input logic         reset,
  hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    FREEZE     = 2'b01,
    FLUSH_PEND = 2'b10,
    UNUSED     = 2'b11
  } state_t;

  state_t cur_state, next_state;
  logic   load_use;
  logic   pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, freeze;
  logic   count_stall, count_flush;
  logic [15:0] stall_cnt, flush_cnt;

  assign load_use = bus.MemRead_ID_EX && (bus.writeReg_ID_EX != 5'd0) &&
                    ((bus.useReg1_IF_ID && (bus.readReg1_IF_ID == bus.writeReg_ID_EX)) ||
                     (bus.useReg2_IF_ID && (bus.readReg2_IF_ID == bus.writeReg_ID_EX)));

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= RUN;
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      cur_state <= next_state;
      if (count_stall && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
      if (count_flush && (flush_cnt != 16'hFFFF))
        flush_cnt <= flush_cnt + 16'd1;
    end
  end

  // Controls are zero-latency; FREEZE leaving on mem_busy=0 acts exactly like RUN.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    freeze      = 1'b0;
    count_stall = 1'b0;
    count_flush = 1'b0;
    next_state  = cur_state;
    if (!reset) begin
      case (cur_state)
        RUN, FREEZE: begin
          if (bus.mem_busy) begin
            freeze     = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            next_state = bus.branch_EX_MEM ? FLUSH_PEND : FREEZE;
          end else begin
            next_state = RUN;
            if (bus.branch_EX_MEM) begin
              ifid_flush  = 1'b1;
              idex_flush  = 1'b1;
              exmem_flush = 1'b1;
              count_flush = 1'b1;
            end else if (load_use) begin
              pc_write    = 1'b0;
              ifid_write  = 1'b0;
              idex_flush  = 1'b1;
              count_stall = 1'b1;
            end
          end
        end
        FLUSH_PEND: begin
          if (bus.mem_busy) begin
            freeze     = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
          end else begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            count_flush = 1'b1;
            next_state  = RUN;
          end
        end
        default: next_state = RUN;
      endcase
    end
  end

  assign bus.PCWrite      = pc_write;
  assign bus.IF_ID_Write  = ifid_write;
  assign bus.IF_ID_Flush  = ifid_flush;
  assign bus.ID_EX_Flush  = idex_flush;
  assign bus.EX_MEM_Flush = exmem_flush;
  assign bus.pipe_freeze  = freeze;
  assign bus.stall_cnt    = stall_cnt;
  assign bus.flush_cnt    = flush_cnt;
  assign bus.state        = cur_state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: single-cycle vector table plus multi-cycle
// freeze, pending-flush, reset and saturation sequences.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   failed = 0;
  int   exp_stall = 0;
  int   exp_flush = 0;

  hazard_ctrl_if bus ();
  hazard_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] r1;
    logic       u1;
    logic [4:0] r2;
    logic       u2;
    logic [4:0] wr;
    logic       mr;
    logic       br;
    logic [5:0] ctrl;
    logic       d_stall;
    logic       d_flush;
  } vec_t;

  vec_t vecs[10];

  // ctrl = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, pipe_freeze}
  localparam logic [5:0] C_IDLE   = 6'b110000;
  localparam logic [5:0] C_STALL  = 6'b000100;
  localparam logic [5:0] C_FLUSH  = 6'b111110;
  localparam logic [5:0] C_FREEZE = 6'b000001;

  function automatic logic [5:0] ctrl();
    return {bus.PCWrite, bus.IF_ID_Write, bus.IF_ID_Flush, bus.ID_EX_Flush,
            bus.EX_MEM_Flush, bus.pipe_freeze};
  endfunction

  task automatic applyStimulus(input logic [4:0] r1, input logic u1,
                               input logic [4:0] r2, input logic u2,
                               input logic [4:0] wr, input logic mr,
                               input logic br, input logic busy);
    bus.readReg1_IF_ID = r1;
    bus.useReg1_IF_ID  = u1;
    bus.readReg2_IF_ID = r2;
    bus.useReg2_IF_ID  = u2;
    bus.writeReg_ID_EX = wr;
    bus.MemRead_ID_EX  = mr;
    bus.branch_EX_MEM  = br;
    bus.mem_busy       = busy;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkCounters(input string name, input logic [1:0] st);
    checkOutput({name, " state"}, 32'(bus.state), 32'(st));
    checkOutput({name, " stall_cnt"}, 32'(bus.stall_cnt), exp_stall);
    checkOutput({name, " flush_cnt"}, 32'(bus.flush_cnt), exp_flush);
  endtask

  task automatic idleInputs();
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    vecs[0] = '{"idle",        5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, C_IDLE,  1'b0, 1'b0};
    vecs[1] = '{"lw_rs2",      5'd3, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, C_STALL, 1'b1, 1'b0};
    vecs[2] = '{"x0_dest",     5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, C_IDLE,  1'b0, 1'b0};
    vecs[3] = '{"rs1_unused",  5'd5, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, C_IDLE,  1'b0, 1'b0};
    vecs[4] = '{"lw_rs1",      5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, C_STALL, 1'b1, 1'b0};
    vecs[5] = '{"no_memread",  5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b0, 1'b0, C_IDLE,  1'b0, 1'b0};
    vecs[6] = '{"branch",      5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, C_FLUSH, 1'b0, 1'b1};
    vecs[7] = '{"branch_lu",   5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, C_FLUSH, 1'b0, 1'b1};
    vecs[8] = '{"rs2_differs", 5'd5, 1'b0, 5'd6, 1'b1, 5'd5, 1'b1, 1'b0, C_IDLE,  1'b0, 1'b0};
    vecs[9] = '{"rs2_unused",  5'd0, 1'b0, 5'd9, 1'b0, 5'd9, 1'b1, 1'b0, C_IDLE,  1'b0, 1'b0};

    // Reset overrides a busy + branch + load-use input pattern
    reset = 1'b1;
    applyStimulus(5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("reset ctrl", 32'(ctrl()), 32'(C_IDLE));
    @(posedge clk); #1;
    checkCounters("reset", 2'b00);
    @(negedge clk);
    reset = 1'b0;
    idleInputs();

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].r1, vecs[i].u1, vecs[i].r2, vecs[i].u2,
                    vecs[i].wr, vecs[i].mr, vecs[i].br, 1'b0);
      #1;
      checkOutput({vecs[i].name, " ctrl"}, 32'(ctrl()), 32'(vecs[i].ctrl));
      @(posedge clk); #1;
      exp_stall += int'(vecs[i].d_stall);
      exp_flush += int'(vecs[i].d_flush);
      checkCounters(vecs[i].name, 2'b00);
    end

    // Three busy cycles, branch arrives in the second; flush lands in the fourth
    @(negedge clk);
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    #1 checkOutput("busy1 ctrl", 32'(ctrl()), 32'(C_FREEZE));
    @(posedge clk); #1 checkCounters("busy1", 2'b01);
    @(negedge clk);
    bus.branch_EX_MEM = 1'b1;
    #1 checkOutput("busy2 ctrl", 32'(ctrl()), 32'(C_FREEZE));
    @(posedge clk); #1 checkCounters("busy2", 2'b10);
    @(negedge clk);
    bus.branch_EX_MEM = 1'b0;
    #1 checkOutput("busy3 ctrl", 32'(ctrl()), 32'(C_FREEZE));
    @(posedge clk); #1 checkCounters("busy3", 2'b10);
    @(negedge clk);
    bus.mem_busy = 1'b0;
    #1 checkOutput("pend_flush ctrl", 32'(ctrl()), 32'(C_FLUSH));
    @(posedge clk); #1;
    exp_flush++;
    checkCounters("pend_flush", 2'b00);
    @(negedge clk);
    #1 checkOutput("after_flush ctrl", 32'(ctrl()), 32'(C_IDLE));
    @(posedge clk); #1 checkCounters("after_flush", 2'b00);

    // Leaving FREEZE with a load-use pending stalls that cycle
    @(negedge clk);
    applyStimulus(5'd4, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1);
    #1 checkOutput("frz_lu busy ctrl", 32'(ctrl()), 32'(C_FREEZE));
    @(posedge clk); #1 checkCounters("frz_lu busy", 2'b01);
    @(negedge clk);
    bus.mem_busy = 1'b0;
    #1 checkOutput("frz_lu release ctrl", 32'(ctrl()), 32'(C_STALL));
    @(posedge clk); #1;
    exp_stall++;
    checkCounters("frz_lu release", 2'b00);

    // Reset during FLUSH_PEND discards the pending flush
    @(negedge clk);
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1 checkCounters("pend_enter", 2'b10);
    @(negedge clk);
    reset = 1'b1;
    idleInputs();
    #1 checkOutput("pend_reset ctrl", 32'(ctrl()), 32'(C_IDLE));
    @(posedge clk); #1;
    exp_stall = 0;
    exp_flush = 0;
    checkCounters("pend_reset", 2'b00);
    @(negedge clk);
    reset = 1'b0;
    #1 checkOutput("post_reset ctrl", 32'(ctrl()), 32'(C_IDLE));
    @(posedge clk); #1 checkCounters("post_reset", 2'b00);

    // Stall counter saturation
    @(negedge clk);
    applyStimulus(5'd5, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    repeat (65534) @(posedge clk);
    #1;
    exp_stall = 32'hFFFE;
    checkCounters("sat_fffe", 2'b00);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      exp_stall = 32'hFFFF;
      checkCounters("sat_hold", 2'b00);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
